// File: rtl/cordic_pkg.sv
// Shared definitions for the rotation-mode CORDIC front end and post-normalizer.
// Holds the Q2.13 pi/2 constant, the fractional bit counts and the quadrant
// code that travels with each transaction.
package cordic_pkg;

  // pi/2 in Q2.13: round(1.5708 * 8192)
  localparam logic signed [15:0] CORDIC_PI_OVER_2_Q = 16'sd12868;

  // Fraction bits of the Q2.13 angle format used by the CORDIC core
  localparam int unsigned CORDIC_FRAC_BITS = 13;

  // Bits of the binary angle below the quadrant field (one quadrant = 2^14)
  localparam int unsigned THETA_FRAC_W = 14;

  // Pre-rotation applied for each quadrant of the input angle
  typedef enum logic [1:0] {
    Q1_NONE = 2'b00,  // no pre-rotation
    Q2_M90  = 2'b01,  // rotate by -90 deg
    Q3_180  = 2'b10,  // rotate by 180 deg
    Q4_P90  = 2'b11   // rotate by +90 deg
  } quadrant_e;

endpackage

// File: rtl/cordic_angle_standardizer.sv
// Angle standardizer: splits a full-circle binary angle into a quadrant code
// and a residual in [0, 90 deg), converting the residual to Q2.13 radians.
// Two-stage valid/ready pipeline, full throughput, capacity of two.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid / in_ready      upstream handshake
//   x_in, y_in               signed vector, passed through
//   theta_in                 unsigned binary angle, 65536 = 360 deg
//   tag_in                   opaque sideband tag
//   out_valid / out_ready    downstream handshake
//   x_out, y_out             registered vector
//   phi_std                  residual angle, Q2.13 radians (0..12867)
//   orig_angle_quadrant      theta_in[15:14]
//   tag_out                  tag of the output transaction
//   busy                     any stage holds valid data
module cordic_angle_standardizer
  import cordic_pkg::*;
#(
  parameter int unsigned        TAG_W       = 4,
  parameter logic signed [15:0] PI_OVER_2_Q = CORDIC_PI_OVER_2_Q
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [15:0]      x_in,
  input  logic signed [15:0]      y_in,
  input  logic        [15:0]      theta_in,
  input  logic        [TAG_W-1:0] tag_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [15:0]      x_out,
  output logic signed [15:0]      y_out,
  output logic signed [15:0]      phi_std,
  output logic        [1:0]       orig_angle_quadrant,
  output logic        [TAG_W-1:0] tag_out,
  output logic                    busy
);

  // Stage 1 state
  logic                    v1_q, v1_d;
  logic signed [15:0]      x1_q, x1_d, y1_q, y1_d;
  logic        [TAG_W-1:0] tag1_q, tag1_d;
  quadrant_e               quad1_q, quad1_d;
  logic        [13:0]      frac1_q, frac1_d;

  // Stage 2 state
  logic                    v2_q, v2_d;
  logic signed [15:0]      x2_q, x2_d, y2_q, y2_d;
  logic        [TAG_W-1:0] tag2_q, tag2_d;
  quadrant_e               quad2_q, quad2_d;
  logic        [15:0]      phi2_q, phi2_d;

  logic ready2, ld1, ld2;

  assign ready2   = !v2_q || out_ready;
  assign in_ready = !v1_q || ready2;
  assign ld1      = in_valid && in_ready;
  assign ld2      = v1_q && ready2;

  always_comb begin
    v1_d    = v1_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    tag1_d  = tag1_q;
    quad1_d = quad1_q;
    frac1_d = frac1_q;
    v2_d    = v2_q;
    x2_d    = x2_q;
    y2_d    = y2_q;
    tag2_d  = tag2_q;
    quad2_d = quad2_q;
    phi2_d  = phi2_q;

    // A stage drained this cycle stays valid only if it is refilled
    if (ld2) begin
      v1_d = 1'b0;
    end
    if (ld1) begin
      v1_d    = 1'b1;
      x1_d    = x_in;
      y1_d    = y_in;
      tag1_d  = tag_in;
      quad1_d = quadrant_e'(theta_in[15:14]);
      frac1_d = theta_in[13:0];
    end

    if (v2_q && out_ready) begin
      v2_d = 1'b0;
    end
    if (ld2) begin
      v2_d    = 1'b1;
      x2_d    = x1_q;
      y2_d    = y1_q;
      tag2_d  = tag1_q;
      quad2_d = quad1_q;
      // 14x14 -> 28-bit unsigned product; dropping 14 LSBs leaves < 2^14
      phi2_d  = 16'((28'(frac1_q) * 28'(PI_OVER_2_Q)) >> THETA_FRAC_W);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      x1_q    <= '0;
      y1_q    <= '0;
      tag1_q  <= '0;
      quad1_q <= Q1_NONE;
      frac1_q <= '0;
      v2_q    <= 1'b0;
      x2_q    <= '0;
      y2_q    <= '0;
      tag2_q  <= '0;
      quad2_q <= Q1_NONE;
      phi2_q  <= '0;
    end else begin
      v1_q    <= v1_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      tag1_q  <= tag1_d;
      quad1_q <= quad1_d;
      frac1_q <= frac1_d;
      v2_q    <= v2_d;
      x2_q    <= x2_d;
      y2_q    <= y2_d;
      tag2_q  <= tag2_d;
      quad2_q <= quad2_d;
      phi2_q  <= phi2_d;
    end
  end

  assign out_valid           = v2_q;
  assign x_out               = x2_q;
  assign y_out               = y2_q;
  assign phi_std             = phi2_q;
  assign orig_angle_quadrant = quad2_q;
  assign tag_out             = tag2_q;
  assign busy                = v1_q || v2_q;

endmodule

// File: tb/tb_cordic_angle_standardizer.sv
module tb_cordic_angle_standardizer;

  localparam int TAG_W = 4;

  logic                    clk;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [15:0]      x_in, y_in;
  logic        [15:0]      theta_in;
  logic        [TAG_W-1:0] tag_in;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [15:0]      x_out, y_out, phi_std;
  logic        [1:0]       orig_angle_quadrant;
  logic        [TAG_W-1:0] tag_out;
  logic                    busy;

  cordic_angle_standardizer #(.TAG_W(TAG_W), .PI_OVER_2_Q(16'sd12868)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .x_in                (x_in),
    .y_in                (y_in),
    .theta_in            (theta_in),
    .tag_in              (tag_in),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .x_out               (x_out),
    .y_out               (y_out),
    .phi_std             (phi_std),
    .orig_angle_quadrant (orig_angle_quadrant),
    .tag_out             (tag_out),
    .busy                (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int rx_count = 0;
  logic in_fired = 1'b0;
  logic [53:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: quadrant is which quarter-turn the angle lies in; residual is
  // the remaining fraction of a quarter-turn scaled to pi/2 rad in Q2.13.
  function automatic logic [53:0] model(input logic [15:0] theta, input logic signed [15:0] x,
                                        input logic signed [15:0] y, input logic [TAG_W-1:0] tag);
    int unsigned th, quad, rem, phi;
    th   = theta;
    quad = th / 16384;
    rem  = th % 16384;
    phi  = (rem * 12868) / 16384;
    return {x, y, 16'(phi), 2'(quad), tag};
  endfunction

  // Handshakes are sampled mid-cycle; they describe the transfer at the next edge.
  always @(negedge clk) begin
    logic [53:0] e;
    if (!rst_n) begin
      exp_q.delete();
      in_fired = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        rx_count++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL scoreboard: unexpected output tag=%0d, expected none", tag_out);
        end else begin
          e = exp_q.pop_front();
          check("scoreboard", 64'({x_out, y_out, phi_std, orig_angle_quadrant, tag_out}), 64'(e));
        end
      end
      in_fired = in_valid && in_ready;
      if (in_fired) exp_q.push_back(model(theta_in, x_in, y_in, tag_in));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0]        theta;
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic [TAG_W-1:0]   tag;
    logic [1:0]         quad;
    logic [15:0]        phi;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int gen;
    int rx0;
    int cyc;

    tbl[0] = '{16'h0000,  16'sd1000, -16'sd500, 4'd3,  2'd0, 16'd0};
    tbl[1] = '{16'h6000,  16'sd7,    16'sd8,    4'd1,  2'd1, 16'd6434};
    tbl[2] = '{16'hA000, -16'sd300,  16'sd299,  4'd2,  2'd2, 16'd6434};
    tbl[3] = '{16'hFFFF,  16'sd32767,-16'sd32768,4'd15,2'd3, 16'd12867};
    tbl[4] = '{16'h4000,  16'sd1,    16'sd2,    4'd4,  2'd1, 16'd0};
    tbl[5] = '{16'h8000,  16'sd3,    16'sd4,    4'd5,  2'd2, 16'd0};
    tbl[6] = '{16'hC000,  16'sd5,    16'sd6,    4'd6,  2'd3, 16'd0};
    tbl[7] = '{16'h3FFF, -16'sd1,   -16'sd2,    4'd7,  2'd0, 16'd12867};
    tbl[8] = '{16'h0002,  16'sd100,  16'sd200,  4'd8,  2'd0, 16'd1};
    tbl[9] = '{16'h2000,  16'sd123, -16'sd456,  4'd9,  2'd0, 16'd6434};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x_in = '0; y_in = '0; theta_in = '0; tag_in = '0;
    #1;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset data", 64'({x_out, y_out, phi_std, orig_angle_quadrant, tag_out}), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("post-reset in_ready", 64'(in_ready), 64'd1);

    // Directed quadrant/residual table, one transaction at a time
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; theta_in = tbl[i].theta; x_in = tbl[i].x; y_in = tbl[i].y; tag_in = tbl[i].tag;
      check("tbl in_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      check("tbl out_valid@1", 64'(out_valid), 64'd0);
      tick();
      check("tbl out_valid@2", 64'(out_valid), 64'd1);
      check("tbl quad", 64'(orig_angle_quadrant), 64'(tbl[i].quad));
      check("tbl phi", 64'(phi_std), 64'(tbl[i].phi));
      check("tbl x", 64'(x_out), 64'(tbl[i].x));
      check("tbl y", 64'(y_out), 64'(tbl[i].y));
      check("tbl tag", 64'(tag_out), 64'(tbl[i].tag));
      tick();
      check("tbl drained", 64'(busy), 64'd0);
    end

    // Throughput: 8 back-to-back transactions
    for (int k = 0; k < 11; k++) begin
      if (k < 8) begin
        in_valid = 1'b1; tag_in = 4'(k); theta_in = 16'($urandom);
        x_in = 16'($urandom); y_in = 16'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      check("thru out_valid", 64'(out_valid), 64'(k >= 2 && k < 10));
      if (k >= 2 && k < 10) check("thru tag order", 64'(tag_out), 64'(k - 2));
      tick();
    end

    // Backpressure: capacity of two, outputs held while stalled
    out_ready = 1'b0;
    in_valid = 1'b1; x_in = 16'sd111; y_in = -16'sd222; theta_in = 16'h5555; tag_in = 4'd10;
    tick();
    x_in = 16'sd333; y_in = 16'sd444; theta_in = 16'h9ABC; tag_in = 4'd11;
    check("bp in_ready 2nd", 64'(in_ready), 64'd1);
    tick();
    x_in = 16'sd555; y_in = 16'sd666; theta_in = 16'hDEF0; tag_in = 4'd12;
    check("bp in_ready full", 64'(in_ready), 64'd0);
    for (int s = 0; s < 5; s++) begin
      tick();
      check("bp in_ready held", 64'(in_ready), 64'd0);
      check("bp out_valid held", 64'(out_valid), 64'd1);
      check("bp x stable", 64'(x_out), 64'(16'sd111));
      check("bp tag stable", 64'(tag_out), 64'd10);
      check("bp phi stable", 64'(phi_std), 64'd4289);
    end
    rx0 = rx_count;
    out_ready = 1'b1;
    #1;
    check("bp in_ready comb", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("bp drained count", 64'(rx_count - rx0), 64'd3);
    check("bp queue empty", 64'(exp_q.size()), 64'd0);

    // Reset with two transactions held
    out_ready = 1'b0;
    in_valid = 1'b1; x_in = 16'sd1234; y_in = -16'sd4321; theta_in = 16'h7123; tag_in = 4'd9;
    tick();
    tag_in = 4'd13; theta_in = 16'hB001;
    tick();
    in_valid = 1'b0;
    check("rst pre busy", 64'(busy), 64'd1);
    check("rst pre out_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst data", 64'({x_out, y_out, phi_std, orig_angle_quadrant, tag_out}), 64'd0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("rst release in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    in_valid = 1'b1; x_in = -16'sd77; y_in = 16'sd88; theta_in = 16'hA000; tag_in = 4'd14;
    tick();
    in_valid = 1'b0;
    tick();
    check("rst after valid", 64'(out_valid), 64'd1);
    check("rst after quad", 64'(orig_angle_quadrant), 64'd2);
    check("rst after phi", 64'(phi_std), 64'd6434);
    check("rst after tag", 64'(tag_out), 64'd14);
    tick();

    // Random stalls on both sides, 1000 transactions
    rx0 = rx_count;
    gen = 0;
    cyc = 0;
    while ((gen < 1000 || in_valid) && cyc < 20000) begin
      if (!in_valid || in_fired) begin
        if (gen < 1000 && ($urandom % 4) != 0) begin
          in_valid = 1'b1; theta_in = 16'($urandom); x_in = 16'($urandom);
          y_in = 16'($urandom); tag_in = 4'($urandom);
          gen++;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = (($urandom % 3) != 0);
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("rand drain", 64'(exp_q.size()), 64'd0);
    check("rand count", 64'(rx_count - rx0), 64'd1000);
    check("rand idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
